// File: rtl/instruction_buffer_pkg.sv
// Shared definitions for the fetch -> instruction buffer -> dispatch path.
//   IF_IB_PACKET : registered fetch output (inst, PC, NPC, valid)
//   IB_DP_PACKET : head entry presented to dispatch (inst, PC, NPC, valid)
//   NOP          : instruction word shown to dispatch when nothing is held
//   IB_DEPTH     : default number of buffer entries
package instruction_buffer_pkg;

  localparam int          IB_DEPTH = 8;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IF_IB_PACKET;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
    logic        valid;
  } IB_DP_PACKET;

  // Value dispatch sees while the buffer holds nothing.
  function automatic IB_DP_PACKET ib_idle_packet();
    IB_DP_PACKET p;
    p      = '0;
    p.inst = NOP;
    return p;
  endfunction

endpackage

// File: rtl/instruction_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for a power-of-two circular buffer.
// Ports:
//   clock, reset     : clock, synchronous active-high reset
//   flush            : empty the buffer next cycle (beats reads and writes)
//   wr_valid         : a write is offered this cycle
//   rd_ready         : the consumer takes the head this cycle
//   head, tail       : read/write pointers, natural power-of-two wrap
//   count            : occupancy, 0..DEPTH
//   full             : count >= DEPTH-1 (one slot held back for the in-flight packet)
//   empty            : count == 0
//   enq, deq         : qualified write/read strobes for the storage array
//   overflow_event   : an offered write was dropped for lack of space
module instruction_buffer_ptr_ctrl
  import instruction_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_valid,
  input  logic             rd_ready,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             enq,
  output logic             deq,
  output logic             overflow_event
);

  localparam logic [CNT_W-1:0] CAP_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH - 1);

  logic at_cap;

  always_comb begin
    empty  = (count == '0);
    full   = (count >= FULL_C);
    at_cap = (count == CAP_C);
    deq    = rd_ready && !empty && !flush;
    // At capacity a write is still accepted when the head leaves in the same
    // cycle: the freed slot is exactly the wrapped tail.
    enq            = wr_valid && !flush && (!at_cap || deq);
    overflow_event = wr_valid && !flush && at_cap && !deq;
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_buffer.sv
// Decoupling FIFO between fetch and dispatch, in program order, show-ahead.
// Ports:
//   clock, reset   : clock, synchronous active-high reset (overrides flush)
//   if_ib_packet   : registered fetch output; valid=0 bubbles are never stored
//   flush          : redirect/squash; discards everything held and in flight
//   dp_ready       : dispatch takes the head entry this cycle
//   ib_dp_packet   : head entry, valid = !ib_empty; idle value when empty
//   ib_full        : back-pressure to fetch, asserted at count >= IB_DEPTH-1
//   ib_empty       : no entries held
//   ib_count       : current occupancy
//   ib_overflow    : sticky, set when a packet was dropped for lack of space
// Handshake: an entry moves to dispatch on any cycle where ib_dp_packet.valid
// and dp_ready are both high and flush is low; fetch is expected to stop
// issuing one cycle after it sees ib_full, the reserve slot absorbs that
// last in-flight packet.
module instruction_buffer
  import instruction_buffer_pkg::*;
#(
  parameter int IB_DEPTH = instruction_buffer_pkg::IB_DEPTH,
  parameter int IB_CNT_W = $clog2(IB_DEPTH) + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  IF_IB_PACKET         if_ib_packet,
  input  logic                flush,
  input  logic                dp_ready,
  output IB_DP_PACKET         ib_dp_packet,
  output logic                ib_full,
  output logic                ib_empty,
  output logic [IB_CNT_W-1:0] ib_count,
  output logic                ib_overflow
);

  localparam int PTR_W = $clog2(IB_DEPTH);

  IB_DP_PACKET      entries [IB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             enq;
  logic             deq;
  logic             overflow_event;

  instruction_buffer_ptr_ctrl #(
    .DEPTH (IB_DEPTH),
    .CNT_W (IB_CNT_W),
    .PTR_W (PTR_W)
  ) u_ptr_ctrl (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .wr_valid       (if_ib_packet.valid),
    .rd_ready       (dp_ready),
    .head           (head),
    .tail           (tail),
    .count          (ib_count),
    .full           (ib_full),
    .empty          (ib_empty),
    .enq            (enq),
    .deq            (deq),
    .overflow_event (overflow_event)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < IB_DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < IB_DEPTH; i++) entries[i].valid <= 1'b0;
    end else begin
      // When full with a simultaneous read and write, head == tail; the write
      // comes second so the new entry stays valid.
      if (deq) entries[head].valid <= 1'b0;
      if (enq) begin
        entries[tail].inst  <= if_ib_packet.inst;
        entries[tail].PC    <= if_ib_packet.PC;
        entries[tail].NPC   <= if_ib_packet.NPC;
        entries[tail].valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)               ib_overflow <= 1'b0;
    else if (overflow_event) ib_overflow <= 1'b1;
  end

  // Driven from registered state only, so a write is visible one cycle later.
  always_comb begin
    if (ib_empty) begin
      ib_dp_packet = ib_idle_packet();
    end else begin
      ib_dp_packet       = entries[head];
      ib_dp_packet.valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_buffer.sv
module tb_instruction_buffer;
  import instruction_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  IF_IB_PACKET       if_ib_packet;
  logic              flush = 1'b0;
  logic              dp_ready = 1'b0;
  IB_DP_PACKET       ib_dp_packet;
  logic              ib_full;
  logic              ib_empty;
  logic [CNT_W-1:0]  ib_count;
  logic              ib_overflow;

  int checks   = 0;
  int failures = 0;

  // clock / reset block
  always #5 clock = ~clock;

  instruction_buffer #(.IB_DEPTH(DEPTH), .IB_CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_ib_packet (if_ib_packet),
    .flush        (flush),
    .dp_ready     (dp_ready),
    .ib_dp_packet (ib_dp_packet),
    .ib_full      (ib_full),
    .ib_empty     (ib_empty),
    .ib_count     (ib_count),
    .ib_overflow  (ib_overflow)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: advance one edge, then settle before looking or driving
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_pkt(input logic v, input logic [31:0] pc);
    if_ib_packet.valid = v;
    if_ib_packet.PC    = pc;
    if_ib_packet.NPC   = pc + 32'd4;
    if_ib_packet.inst  = 32'hA000_0000 | pc;
  endtask

  task automatic idle();
    drive_pkt(1'b0, 32'h0);
    dp_ready = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    IB_DP_PACKET idle_pkt;
    idle_pkt      = '0;
    idle_pkt.inst = 32'h0000_0013;
    check({tag, "_pkt"},      128'(ib_dp_packet), 128'(idle_pkt));
    check({tag, "_empty"},    128'(ib_empty),     128'(1));
    check({tag, "_full"},     128'(ib_full),      128'(0));
    check({tag, "_count"},    128'(ib_count),     128'(0));
    check({tag, "_overflow"}, 128'(ib_overflow),  128'(0));
  endtask

  logic        fetch_go;
  logic        next_go;
  int          first_full_count;
  logic [31:0] exp_q[$];

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_state("reset");

    // three packets held, then drained in order
    for (int i = 0; i < 3; i++) begin
      drive_pkt(1'b1, 32'(4 * i));
      tick();
    end
    idle();
    check("t1_count", 128'(ib_count), 128'(3));
    check("t1_head_pc", 128'(ib_dp_packet.PC), 128'(32'h0));
    check("t1_head_npc", 128'(ib_dp_packet.NPC), 128'(32'h4));
    check("t1_head_inst", 128'(ib_dp_packet.inst), 128'(32'hA000_0000));
    dp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t1_drain_pc", 128'(ib_dp_packet.PC), 128'(32'(4 * i)));
      check("t1_drain_valid", 128'(ib_dp_packet.valid), 128'(1));
      tick();
    end
    dp_ready = 1'b0;
    check("t1_empty", 128'(ib_empty), 128'(1));
    check("t1_valid0", 128'(ib_dp_packet.valid), 128'(0));

    // fetch gated by ib_full with one cycle of registered latency
    fetch_go = 1'b1;
    first_full_count = -1;
    for (int k = 0; k < 12; k++) begin
      if (ib_full && first_full_count < 0) first_full_count = int'(ib_count);
      drive_pkt(fetch_go, 32'h100 + 32'(4 * k));
      next_go = !ib_full;
      tick();
      fetch_go = next_go;
    end
    idle();
    check("t2_full_at", 128'(first_full_count), 128'(7));
    check("t2_count", 128'(ib_count), 128'(8));
    check("t2_full", 128'(ib_full), 128'(1));
    check("t2_overflow", 128'(ib_overflow), 128'(0));

    // full buffer: simultaneous write and read, order kept across the wrap
    check("t3_head_before", 128'(ib_dp_packet.PC), 128'(32'h100));
    drive_pkt(1'b1, 32'h200);
    dp_ready = 1'b1;
    tick();
    idle();
    check("t3_count", 128'(ib_count), 128'(8));
    check("t3_head_after", 128'(ib_dp_packet.PC), 128'(32'h104));
    check("t3_overflow", 128'(ib_overflow), 128'(0));
    for (int k = 1; k < 8; k++) exp_q.push_back(32'h100 + 32'(4 * k));
    exp_q.push_back(32'h200);
    dp_ready = 1'b1;
    while (exp_q.size() > 0) begin
      check("t3_drain_pc", 128'(ib_dp_packet.PC), 128'(exp_q.pop_front()));
      tick();
    end
    dp_ready = 1'b0;
    check("t3_empty", 128'(ib_empty), 128'(1));

    // flush at count 5 with a packet and dp_ready in the same cycle
    for (int i = 0; i < 5; i++) begin
      drive_pkt(1'b1, 32'h300 + 32'(4 * i));
      tick();
    end
    idle();
    check("t4_count5", 128'(ib_count), 128'(5));
    flush = 1'b1;
    dp_ready = 1'b1;
    drive_pkt(1'b1, 32'h380);
    #1;
    check("t4_head_in_flush", 128'(ib_dp_packet.PC), 128'(32'h300));
    tick();
    idle();
    check("t4_count0", 128'(ib_count), 128'(0));
    check("t4_empty", 128'(ib_empty), 128'(1));
    check("t4_valid0", 128'(ib_dp_packet.valid), 128'(0));
    drive_pkt(1'b1, 32'h40);
    tick();
    idle();
    check("t4_new_head", 128'(ib_dp_packet.PC), 128'(32'h40));
    check("t4_count1", 128'(ib_count), 128'(1));
    dp_ready = 1'b1;
    tick();
    idle();
    check("t4_drained", 128'(ib_empty), 128'(1));

    // bubbles are never stored
    drive_pkt(1'b1, 32'h0); tick();
    drive_pkt(1'b0, 32'h4); tick();
    drive_pkt(1'b1, 32'h8); tick();
    drive_pkt(1'b0, 32'hC); tick();
    idle();
    check("t5_count", 128'(ib_count), 128'(2));
    dp_ready = 1'b1;
    check("t5_pc0", 128'(ib_dp_packet.PC), 128'(32'h0));
    tick();
    check("t5_pc1", 128'(ib_dp_packet.PC), 128'(32'h8));
    tick();
    idle();
    check("t5_empty", 128'(ib_empty), 128'(1));

    // ignore ib_full and force a write at capacity
    for (int i = 0; i < 8; i++) begin
      drive_pkt(1'b1, 32'h500 + 32'(4 * i));
      tick();
    end
    check("t6_count8", 128'(ib_count), 128'(8));
    check("t6_no_ovf_yet", 128'(ib_overflow), 128'(0));
    drive_pkt(1'b1, 32'h600);
    tick();
    idle();
    check("t6_overflow", 128'(ib_overflow), 128'(1));
    check("t6_count_sat", 128'(ib_count), 128'(8));
    check("t6_head_kept", 128'(ib_dp_packet.PC), 128'(32'h500));
    tick();
    check("t6_ovf_held", 128'(ib_overflow), 128'(1));
    flush = 1'b1;
    tick();
    idle();
    check("t6_ovf_after_flush", 128'(ib_overflow), 128'(1));
    check("t6_flush_empty", 128'(ib_empty), 128'(1));
    drive_pkt(1'b1, 32'h700);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
